morse_char_decoder: RTL and testbench
=====================================

# morse_char_decoder

Downstream consumer of the Morse detector: accepts its one-cycle `dot`/`dash`/`ch_s`/`w_s` strobes, each qualified by `en`. Accumulates up to five symbols per character and translates each completed symbol group to an uppercase ASCII byte. Emits a space byte at word boundaries. Bytes are buffered in a small FIFO and presented on a valid/ready byte stream for a UART/display stage.

## Interface
- `DEPTH`, 4: output FIFO entries; power of two, 2..16.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `dot` in 1: dot strobe; valid only when `en`=1.
- `dash` in 1: dash strobe; valid only when `en`=1.
- `ch_s` in 1: character-space strobe; valid only when `en`=1.
- `w_s` in 1: word-space strobe; valid only when `en`=1.
- `en` in 1: event qualifier; when 0, all four strobes are ignored.
- `out_ready` in 1: downstream accepts a byte on a cycle with `out_valid`=1.
- `out_valid` out 1: FIFO non-empty.
- `out_data` out 8: FIFO head byte; meaningful only when `out_valid`=1.
- `sym_count` out 3: symbols held for the current character, 0..5.
- `drop_err` out 1: sticky; set when a byte is discarded because the FIFO is full.

## Operation
- An event is sampled on an edge with `en`=1 and exactly one of `dot`/`dash`/`ch_s`/`w_s` high.
  - `en`=1 with zero or multiple strobes high is ignored: no state change.
- Symbol register: 5-bit pattern plus count. Each `dot` shifts in 0 and each `dash` shifts in 1, at the LSB; count increments.
- Overlong flag: a 6th symbol sets it. It and any further symbols leave the pattern and count (5) unchanged.
- Lookup (combinational from the pattern, count and overlong flag):
  - International Morse (ITU-R M.1677-1) letters A–Z map to 0x41–0x5A.
  - Digits 0–9 map to 0x30–0x39.
  - Any other pattern, count 0 with a forced emit, or overlong maps to `?` (0x3F).
- `ch_s` event:
  - count>0: write the lookup byte to the FIFO and clear pattern, count and overlong flag.
  - count=0: no write.
- `w_s` event:
  - count>0: write the lookup byte and clear the symbol register. Go to EMIT_SPACE and write 0x20 on the next edge.
  - count=0: write 0x20 on this edge directly.
- Space suppression: a space is not written if the last byte written since reset was 0x20, or if nothing has been written since reset.
- State machine:
  - ACCUM: default after reset.
  - EMIT_SPACE: exactly one cycle, then returns to ACCUM.
  - Events sampled while in EMIT_SPACE are processed normally; the symbol register is independent.
  - A `ch_s`/`w_s` event sampled in EMIT_SPACE that also needs a FIFO write gets the write port on that edge. The pending space is then written on the following edge, and EMIT_SPACE holds one extra cycle. At most one FIFO write per edge.
- FIFO: `DEPTH` entries with read/write pointers wrapping modulo `DEPTH`.
  - Pop on `out_valid & out_ready`.
  - A write with the FIFO full and no pop on the same edge is discarded and sets `drop_err`.
  - A write on the same edge as a pop when full is accepted.
- `drop_err` clears only on `reset`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0x00, `sym_count`=0, `drop_err`=0, state ACCUM, FIFO empty, last-written marker = none.
- Reset asserted mid-character or in EMIT_SPACE discards all pending symbols, the pending space and FIFO contents immediately.
- Byte latency: the event is sampled at edge N; the FIFO write happens at edge N. `out_valid`=1 after edge N if the FIFO was empty.
- A `w_s` with pending symbols writes the character at edge N and the space at edge N+1.
- `sym_count` reflects the symbol register after each edge.
- `out_data` and `out_valid` are registered/FIFO outputs with no combinational path from inputs.

## Test plan
- Dot, dash, `ch_s` (each with `en`) and `out_ready`=1: one byte 0x41 (`A`). `out_valid` high for one cycle. `sym_count` goes 1,2,0.
- Dash×3, `w_s`: 0x4F at edge N, 0x20 at edge N+1. A second immediate `w_s` emits no extra space.
- Dot×6 then `ch_s`: `sym_count` saturates at 5, byte 0x3F. Dot,dash,dash,dash,dash, `ch_s`: byte 0x31 (`1`).
- `out_ready`=0 while five `E` characters are sent (dot, `ch_s` ×5): first 4 bytes 0x45 retained, 5th dropped, `drop_err`=1. Then `out_ready`=1 drains exactly 4 bytes.
- `en`=0 with `dot` pulses, and `en`=1 with `dot`&`dash` together: `sym_count` stays 0, no output.
- Assert `reset` asynchronously between edges with 3 symbols pending and 2 bytes buffered: all outputs go to their reset values before the next edge. A subsequent dot, `ch_s` yields 0x45 only.

Source files
------------

// File: rtl/morse_char_decoder_if.sv
// Strobe inputs from the Morse detector and the byte-stream output of the decoder.
interface morse_char_decoder_if;
    logic       dot;
    logic       dash;
    logic       ch_s;
    logic       w_s;
    logic       en;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] sym_count;
    logic       drop_err;

    modport master (
        output dot, dash, ch_s, w_s, en, out_ready,
        input  out_valid, out_data, sym_count, drop_err
    );
    modport slave (
        input  dot, dash, ch_s, w_s, en, out_ready,
        output out_valid, out_data, sym_count, drop_err
    );
endinterface

// File: rtl/morse_char_decoder.sv
// Collects dot/dash symbols into characters, translates them to ASCII and
// queues the bytes (plus word spaces) in a small FIFO for a byte-stream consumer.
module morse_char_decoder #(
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    morse_char_decoder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] UNKNOWN = 8'h3F;

    typedef enum logic {ACCUM, EMIT_SPACE} state_t;

    state_t     state, state_d;
    logic [4:0] pat;
    logic [2:0] cnt;
    logic       ovl;
    logic       has_wr, last_sp;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   fcnt;

    logic       ev, ev_sym, ev_dash, ev_ch, ev_ws, char_wr;
    logic       wr_req, push, pop, full;
    logic [7:0] wr_data, lut;

    // The most recent symbol sits at the LSB, so the first symbol is the
    // MSB of the count-wide field; unused upper bits stay zero.
    function automatic logic [7:0] lookup(input logic [2:0] n, input logic [4:0] p, input logic o);
        logic [7:0] r;
        r = UNKNOWN;
        if (!o) begin
            case ({n, p})
                {3'd2, 5'b00001}: r = 8'h41; // A
                {3'd4, 5'b01000}: r = 8'h42; // B
                {3'd4, 5'b01010}: r = 8'h43; // C
                {3'd3, 5'b00100}: r = 8'h44; // D
                {3'd1, 5'b00000}: r = 8'h45; // E
                {3'd4, 5'b00010}: r = 8'h46; // F
                {3'd3, 5'b00110}: r = 8'h47; // G
                {3'd4, 5'b00000}: r = 8'h48; // H
                {3'd2, 5'b00000}: r = 8'h49; // I
                {3'd4, 5'b00111}: r = 8'h4A; // J
                {3'd3, 5'b00101}: r = 8'h4B; // K
                {3'd4, 5'b00100}: r = 8'h4C; // L
                {3'd2, 5'b00011}: r = 8'h4D; // M
                {3'd2, 5'b00010}: r = 8'h4E; // N
                {3'd3, 5'b00111}: r = 8'h4F; // O
                {3'd4, 5'b00110}: r = 8'h50; // P
                {3'd4, 5'b01101}: r = 8'h51; // Q
                {3'd3, 5'b00010}: r = 8'h52; // R
                {3'd3, 5'b00000}: r = 8'h53; // S
                {3'd1, 5'b00001}: r = 8'h54; // T
                {3'd3, 5'b00001}: r = 8'h55; // U
                {3'd4, 5'b00001}: r = 8'h56; // V
                {3'd3, 5'b00011}: r = 8'h57; // W
                {3'd4, 5'b01001}: r = 8'h58; // X
                {3'd4, 5'b01011}: r = 8'h59; // Y
                {3'd4, 5'b01100}: r = 8'h5A; // Z
                {3'd5, 5'b11111}: r = 8'h30;
                {3'd5, 5'b01111}: r = 8'h31;
                {3'd5, 5'b00111}: r = 8'h32;
                {3'd5, 5'b00011}: r = 8'h33;
                {3'd5, 5'b00001}: r = 8'h34;
                {3'd5, 5'b00000}: r = 8'h35;
                {3'd5, 5'b10000}: r = 8'h36;
                {3'd5, 5'b11000}: r = 8'h37;
                {3'd5, 5'b11100}: r = 8'h38;
                {3'd5, 5'b11110}: r = 8'h39;
                default:          r = UNKNOWN;
            endcase
        end
        return r;
    endfunction

    assign ev      = bus.en & $onehot({bus.dot, bus.dash, bus.ch_s, bus.w_s});
    assign ev_sym  = ev & (bus.dot | bus.dash);
    assign ev_dash = ev & bus.dash;
    assign ev_ch   = ev & bus.ch_s;
    assign ev_ws   = ev & bus.w_s;
    assign char_wr = (ev_ch | ev_ws) & (cnt != 3'd0);
    assign lut     = lookup(cnt, pat, ovl);

    // A character write always wins the single write port; a pending space waits.
    always_comb begin
        state_d = state;
        wr_req  = 1'b0;
        wr_data = 8'h00;
        case (state)
            ACCUM: begin
                if (char_wr) begin
                    wr_req  = 1'b1;
                    wr_data = lut;
                    if (ev_ws) state_d = EMIT_SPACE;
                end else if (ev_ws) begin
                    wr_req  = has_wr & ~last_sp;
                    wr_data = SPACE;
                end
            end
            EMIT_SPACE: begin
                if (char_wr) begin
                    wr_req  = 1'b1;
                    wr_data = lut;
                end else begin
                    wr_req  = has_wr & ~last_sp;
                    wr_data = SPACE;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACCUM;
        else       state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat <= 5'd0;
            cnt <= 3'd0;
            ovl <= 1'b0;
        end else if (ev_sym) begin
            if (cnt == 3'd5) begin
                ovl <= 1'b1;
            end else begin
                pat <= {pat[3:0], ev_dash};
                cnt <= cnt + 3'd1;
            end
        end else if (char_wr) begin
            pat <= 5'd0;
            cnt <= 3'd0;
            ovl <= 1'b0;
        end
    end

    // Last-written marker tracks write requests, whether or not the FIFO had room.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            has_wr  <= 1'b0;
            last_sp <= 1'b0;
        end else if (wr_req) begin
            has_wr  <= 1'b1;
            last_sp <= (wr_data == SPACE);
        end
    end

    assign full = (fcnt == (AW+1)'(DEPTH));
    assign pop  = (fcnt != '0) & bus.out_ready;
    assign push = wr_req & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            fcnt         <= '0;
            bus.drop_err <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
            if (wr_req & ~push) bus.drop_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_data;
    end

    assign bus.out_valid = (fcnt != '0);
    assign bus.out_data  = bus.out_valid ? mem[rptr] : 8'h00;
    assign bus.sym_count = cnt;
endmodule

// File: tb/tb_morse_char_decoder.sv
// Scenario bench for morse_char_decoder: expected bytes are queued as stimulus
// is driven and checked against the stream as it is consumed.
module tb_morse_char_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    morse_char_decoder_if bus();

    morse_char_decoder #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Consumer side: a byte seen with valid&ready here is popped on the next rising edge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL stream_byte: got unexpected byte %02h, expected none", bus.out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.out_data !== e)
                    $display("FAIL stream_byte: got %02h, expected %02h", bus.out_data, e);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic d, input logic da, input logic c, input logic w, input logic e);
        bus.dot = d; bus.dash = da; bus.ch_s = c; bus.w_s = w; bus.en = e;
        tick();
        bus.dot = 0; bus.dash = 0; bus.ch_s = 0; bus.w_s = 0; bus.en = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0)
            $display("FAIL %s_drain: %0d bytes outstanding, out_valid=%b, expected 0 and 0", name, exp_q.size(), bus.out_valid);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.sym_count, bus.drop_err} !== 13'd0)
            $display("FAIL reset_state: got valid=%b data=%02h cnt=%0d drop=%b, expected all 0",
                     bus.out_valid, bus.out_data, bus.sym_count, bus.drop_err);
        else n_pass++;
        // Leading space after reset is suppressed.
        drive(0, 0, 0, 1, 1);
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL leading_space: out_valid=%b, expected 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_letter_a();
        bus.out_ready = 1;
        drive(1, 0, 0, 0, 1);
        n_checks++;
        if (bus.sym_count !== 3'd1) $display("FAIL a_count1: got %0d, expected 1", bus.sym_count); else n_pass++;
        drive(0, 1, 0, 0, 1);
        n_checks++;
        if (bus.sym_count !== 3'd2) $display("FAIL a_count2: got %0d, expected 2", bus.sym_count); else n_pass++;
        exp_q.push_back(8'h41);
        drive(0, 0, 1, 0, 1);
        n_checks++;
        if (bus.sym_count !== 3'd0 || bus.out_valid !== 1'b1)
            $display("FAIL a_emit: cnt=%0d valid=%b, expected 0 and 1", bus.sym_count, bus.out_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL a_one_cycle: out_valid=%b, expected 0", bus.out_valid); else n_pass++;
        drain("a");
    endtask

    task automatic test_word();
        bus.out_ready = 1;
        repeat (3) drive(0, 1, 0, 0, 1);
        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h20);
        drive(0, 0, 0, 1, 1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h4F)
            $display("FAIL word_char: valid=%b data=%02h, expected 1 and 4f", bus.out_valid, bus.out_data);
        else n_pass++;
        drive(0, 0, 0, 1, 1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h20)
            $display("FAIL word_space: valid=%b data=%02h, expected 1 and 20", bus.out_valid, bus.out_data);
        else n_pass++;
        drive(0, 0, 0, 1, 1);
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL word_no_extra_space: out_valid=%b, expected 0", bus.out_valid); else n_pass++;
        drain("word");
    endtask

    task automatic test_overlong();
        bus.out_ready = 1;
        repeat (5) drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        n_checks++;
        if (bus.sym_count !== 3'd5) $display("FAIL overlong_sat: got %0d, expected 5", bus.sym_count); else n_pass++;
        exp_q.push_back(8'h3F);
        drive(0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 1);
        repeat (4) drive(0, 1, 0, 0, 1);
        exp_q.push_back(8'h31);
        drive(0, 0, 1, 0, 1);
        drain("overlong");
    endtask

    task automatic test_drop();
        bus.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'h45);
            drive(1, 0, 0, 0, 1);
            drive(0, 0, 1, 0, 1);
        end
        n_checks++;
        if (bus.drop_err !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h45)
            $display("FAIL drop_flag: drop=%b valid=%b data=%02h, expected 1 1 45", bus.drop_err, bus.out_valid, bus.out_data);
        else n_pass++;
        bus.out_ready = 1;
        drain("drop");
        n_checks++;
        if (bus.drop_err !== 1'b1) $display("FAIL drop_sticky: got %b, expected 1", bus.drop_err); else n_pass++;
    endtask

    task automatic test_ignored();
        bus.out_ready = 1;
        repeat (3) drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1);
        drive(0, 0, 1, 1, 1);
        n_checks++;
        if (bus.sym_count !== 3'd0 || bus.out_valid !== 1'b0)
            $display("FAIL ignored: cnt=%0d valid=%b, expected 0 and 0", bus.sym_count, bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1;
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h54);
        exp_q.push_back(8'h20);
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 1);
        n_checks++;
        if (bus.sym_count !== 3'd1) $display("FAIL b2b_count: got %0d, expected 1", bus.sym_count); else n_pass++;
        drive(0, 0, 0, 1, 1);
        drain("b2b");
    endtask

    task automatic test_async_reset();
        bus.out_ready = 0;
        repeat (2) begin
            drive(1, 0, 0, 0, 1);
            drive(0, 0, 1, 0, 1);
        end
        drive(1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        n_checks++;
        if (bus.sym_count !== 3'd3 || bus.out_valid !== 1'b1)
            $display("FAIL pre_reset: cnt=%0d valid=%b, expected 3 and 1", bus.sym_count, bus.out_valid);
        else n_pass++;
        #2 reset = 1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.sym_count, bus.drop_err} !== 13'd0)
            $display("FAIL async_reset: valid=%b data=%02h cnt=%0d drop=%b, expected all 0",
                     bus.out_valid, bus.out_data, bus.sym_count, bus.drop_err);
        else n_pass++;
        tick();
        reset = 0;
        bus.out_ready = 1;
        exp_q.push_back(8'h45);
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        drain("post_reset");
    endtask

    initial begin
        bus.dot = 0; bus.dash = 0; bus.ch_s = 0; bus.w_s = 0; bus.en = 0; bus.out_ready = 0;
        repeat (2) tick();
        reset = 0;
        test_reset();
        test_letter_a();
        test_word();
        test_overlong();
        test_drop();
        test_ignored();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
